// File: rtl/alu_issue_ctrl.sv
// Issue-side controller for the registered 32-bit ALU: decodes RISC-V OP/OP-IMM requests,
// holds ALU operands while the ALU settles, then returns a tagged valid/ready response.
module alu_issue_ctrl #(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7b5,
  input  logic             req_is_imm,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [31:0]      req_imm,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_Z,
  input  logic             alu_N,
  input  logic             alu_C,
  input  logic             alu_V,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal
);

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned CNT_W  = 3;

  localparam logic [CTRL_W-1:0] CTRL_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] CTRL_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] CTRL_OR   = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_AND  = 4'b0011;
  localparam logic [CTRL_W-1:0] CTRL_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] CTRL_SLL  = 4'b0101;
  localparam logic [CTRL_W-1:0] CTRL_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] CTRL_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] CTRL_SLTU = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    CAPT = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CTRL_W-1:0] dec_control;
  logic              dec_illegal;
  logic              accept;

  // funct3/funct7b5 decode; SRA and SLL-with-bit30 have no ALU encoding
  always_comb begin
    dec_control = CTRL_ADD;
    dec_illegal = 1'b0;
    case (req_funct3)
      3'b000: dec_control = (req_funct7b5 && !req_is_imm) ? CTRL_SUB : CTRL_ADD;
      3'b001: begin
        dec_control = CTRL_SLL;
        dec_illegal = req_funct7b5;
      end
      3'b010: dec_control = CTRL_SLT;
      3'b011: dec_control = CTRL_SLTU;
      3'b100: dec_control = CTRL_XOR;
      3'b101: begin
        dec_control = CTRL_SRL;
        dec_illegal = req_funct7b5;
      end
      3'b110: dec_control = CTRL_OR;
      3'b111: dec_control = CTRL_AND;
      default: begin
        dec_control = CTRL_ADD;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // Control FSM; ALU inputs only move on a legal accept so the ALU stays quiet otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_tag     <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_tag     <= req_tag;
            rsp_illegal <= dec_illegal;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            if (dec_illegal) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_A       <= req_rs1;
              alu_B       <= req_is_imm ? req_imm : req_rs2;
              alu_control <= dec_control;
              wait_cnt    <= CNT_W'(ALU_LAT);
              state       <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= CAPT;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        CAPT: begin
          rsp_result <= alu_result;
          rsp_flags  <= {alu_Z, alu_N, alu_C, alu_V};
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU sits behind the DUT, and expected
// responses come from an instruction-level reference model.
module tb_alu_issue_ctrl;

  localparam int unsigned TAG_W     = 4;
  localparam int unsigned ALU_LAT   = 1;
  localparam int          CYC_LIMIT = 60;
  localparam longint      MAX_S     = 64'sd2147483647;
  localparam longint      MIN_S     = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic             req_funct7b5;
  logic             req_is_imm;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [31:0]      req_imm;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      alu_A;
  logic [31:0]      alu_B;
  logic [3:0]       alu_control;
  logic [31:0]      alu_result;
  logic             alu_Z;
  logic             alu_N;
  logic             alu_C;
  logic             alu_V;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_result;
  logic [3:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  alu_issue_ctrl #(.TAG_W(TAG_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_funct3(req_funct3), .req_funct7b5(req_funct7b5), .req_is_imm(req_is_imm),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_tag(req_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
    .alu_result(alu_result), .alu_Z(alu_Z), .alu_N(alu_N), .alu_C(alu_C), .alu_V(alu_V),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      result;
    logic [3:0]       flags;
    logic [TAG_W-1:0] tag;
    logic             illegal;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [3:0]       ctrl;
    int               acc_edge;
    int               lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hold_low = 0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [3:0]  last_ctrl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Instruction-level reference: meaning of each RISC-V op, flags from plain arithmetic
  function automatic void ref_model(input logic [2:0] f3, input logic f7, input logic is_imm,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic [3:0] flg,
                                    output logic ill, output logic [3:0] code);
    longint sa, sbv, wide;
    logic   c, v;
    sa   = longint'($signed(a));
    sbv  = longint'($signed(b));
    c    = 1'b0;
    v    = 1'b0;
    ill  = 1'b0;
    res  = '0;
    code = 4'b0000;
    case (f3)
      3'd0: begin
        if (f7 && !is_imm) begin
          code = 4'b0001; res = a - b; c = (a >= b); wide = sa - sbv;
        end else begin
          code = 4'b0000; res = a + b; c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; wide = sa + sbv;
        end
        v = (wide > MAX_S) || (wide < MIN_S);
      end
      3'd1: if (f7) ill = 1'b1; else begin code = 4'b0101; res = a << b[4:0]; end
      3'd2: begin code = 4'b0111; res = (sa < sbv) ? 32'd1 : 32'd0; end
      3'd3: begin code = 4'b1000; res = (a < b) ? 32'd1 : 32'd0; end
      3'd4: begin code = 4'b0100; res = a ^ b; end
      3'd5: if (f7) ill = 1'b1; else begin code = 4'b0110; res = a >> b[4:0]; end
      3'd6: begin code = 4'b0010; res = a | b; end
      default: begin code = 4'b0011; res = a & b; end
    endcase
    if (ill) begin
      res = '0;
      flg = '0;
    end else begin
      flg = {res == 32'd0, res[31], c, v};
    end
  endfunction

  // Behavioural registered ALU driven by the DUT's control code
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] ctl);
    logic [32:0] s;
    logic [31:0] bb, r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (ctl)
      4'b0000, 4'b0001: begin
        bb = (ctl == 4'b0001) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + 33'(ctl == 4'b0001);
        r  = s[31:0];
        c  = s[32];
        v  = (a[31] == bb[31]) && (r[31] != a[31]);
      end
      4'b0010: r = a | b;
      4'b0011: r = a & b;
      4'b0100: r = a ^ b;
      4'b0101: r = a << b[4:0];
      4'b0110: r = a >> b[4:0];
      4'b0111: r = {31'd0, $signed(a) < $signed(b)};
      4'b1000: r = {31'd0, a < b};
      default: r = '0;
    endcase
    return {r == 32'd0, r[31], c, v, r};
  endfunction

  logic [35:0] alu_pipe [ALU_LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_model(alu_A, alu_B, alu_control);
    for (int i = 1; i < int'(ALU_LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {alu_Z, alu_N, alu_C, alu_V, alu_result} = alu_pipe[ALU_LAT-1];

  task automatic issue(input logic [2:0] f3, input logic f7, input logic is_imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [TAG_W-1:0] tag);
    exp_t        e;
    logic [31:0] b;
    int          waited;
    @(negedge clk);
    req_funct3 = f3; req_funct7b5 = f7; req_is_imm = is_imm;
    req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_tag = tag;
    req_valid = 1'b1;
    b = is_imm ? imm : rs2;
    ref_model(f3, f7, is_imm, rs1, b, e.result, e.flags, e.illegal, e.ctrl);
    waited = 0;
    while (!req_ready && waited < CYC_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    if (!e.illegal) begin
      last_a = rs1; last_b = b; last_ctrl = e.ctrl;
    end
    e.a = last_a; e.b = last_b; e.ctrl = last_ctrl; e.tag = tag;
    e.acc_edge = cyc + 1;
    e.lat = e.illegal ? 0 : int'(ALU_LAT) + 2;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb.size() > 0 || rsp_valid) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: drives rsp_ready, checks latency, hold-while-stalled and response contents
  logic             prev_valid = 1'b0;
  logic             prev_stall = 1'b0;
  logic [31:0]      p_res;
  logic [3:0]       p_flg;
  logic [TAG_W-1:0] p_tag;
  logic             p_ill;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      rsp_ready  = 1'b0;
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid",   64'(rsp_valid),   64'd1);
        chk("hold_result",  64'(rsp_result),  64'(p_res));
        chk("hold_flags",   64'(rsp_flags),   64'(p_flg));
        chk("hold_tag",     64'(rsp_tag),     64'(p_tag));
        chk("hold_illegal", 64'(rsp_illegal), 64'(p_ill));
      end
      if (rsp_valid) begin
        chk("req_ready_busy", 64'(req_ready), 64'd0);
        if (!prev_valid) begin
          if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          else chk("latency", 64'(cyc - sb[0].acc_edge), 64'(sb[0].lat));
        end
        if (hold_low > 0) begin
          rsp_ready = 1'b0;
          hold_low--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (rsp_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_result",  64'(rsp_result),  64'(e.result));
          chk("rsp_flags",   64'(rsp_flags),   64'(e.flags));
          chk("rsp_tag",     64'(rsp_tag),     64'(e.tag));
          chk("rsp_illegal", 64'(rsp_illegal), 64'(e.illegal));
          chk("alu_A",       64'(alu_A),       64'(e.a));
          chk("alu_B",       64'(alu_B),       64'(e.b));
          chk("alu_control", 64'(alu_control), 64'(e.ctrl));
        end
        prev_stall = !rsp_ready;
        p_res = rsp_result; p_flg = rsp_flags; p_tag = rsp_tag; p_ill = rsp_illegal;
      end else begin
        rsp_ready  = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic check_cleared(input string tag_name);
    chk({tag_name, "_rsp_valid"},   64'(rsp_valid),   64'd0);
    chk({tag_name, "_req_ready"},   64'(req_ready),   64'd0);
    chk({tag_name, "_alu_A"},       64'(alu_A),       64'd0);
    chk({tag_name, "_alu_B"},       64'(alu_B),       64'd0);
    chk({tag_name, "_alu_control"}, 64'(alu_control), 64'd0);
    chk({tag_name, "_rsp_result"},  64'(rsp_result),  64'd0);
    chk({tag_name, "_rsp_flags"},   64'(rsp_flags),   64'd0);
    chk({tag_name, "_rsp_tag"},     64'(rsp_tag),     64'd0);
    chk({tag_name, "_rsp_illegal"}, 64'(rsp_illegal), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_funct3 = '0; req_funct7b5 = 1'b0; req_is_imm = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_tag = '0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset = 1'b0;
    #1 chk("ready_after_reset", 64'(req_ready), 64'd1);

    issue(3'b000, 1'b0, 1'b0, 32'd5, 32'd3, 32'd0, 4'd2);
    issue(3'b000, 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 4'd3);
    issue(3'b000, 1'b1, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFF9, 4'd4);
    issue(3'b101, 1'b1, 1'b0, 32'h1234_5678, 32'd4, 32'd0, 4'd5);
    issue(3'b001, 1'b1, 1'b1, 32'hAAAA_5555, 32'd0, 32'd3, 4'd6);
    issue(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'd0, 32'd31, 4'd7);
    hold_low = 5;
    issue(3'b110, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 4'd8);
    issue(3'b011, 1'b1, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd9);
    drain();

    // Reset while the op is waiting on the ALU: it must vanish without a response
    issue(3'b100, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 32'd0, 4'd10);
    @(negedge clk);
    reset = 1'b1;
    #1 check_cleared("midop_reset");
    repeat (2) @(negedge clk);
    sb.delete();
    last_a = '0; last_b = '0; last_ctrl = '0;
    reset = 1'b0;
    #1 chk("ready_after_midop_reset", 64'(req_ready), 64'd1);
    repeat (8) @(negedge clk);
    chk("no_stale_rsp", 64'(rsp_valid), 64'd0);

    for (int n = 0; n < 150; n++) begin
      logic [2:0]       f3;
      logic             f7, im;
      logic [TAG_W-1:0] tg;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 3) == 0);
      im = 1'($urandom_range(0, 1));
      tg = TAG_W'($urandom);
      issue(f3, f7, im, pick(), pick(), pick(), tg);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
